// File: rtl/diram_sweep_if.sv
// Bus bundle for diram_sweep: write port, clear request, two read ports and status.
// master drives the table (rule loader / readers), slave is the RAM itself.
interface diram_sweep_if #(
    parameter int WIDTH = 6,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] DIN;
    logic             W;
    logic [AW-1:0]    WADD;
    logic             CLR;
    logic [AW-1:0]    RADD_A;
    logic [AW-1:0]    RADD_B;
    logic [WIDTH-1:0] DOUT_A;
    logic [WIDTH-1:0] DOUT_B;
    logic             READY;
    logic             WERR;

    modport master (
        output DIN, W, WADD, CLR, RADD_A, RADD_B,
        input  DOUT_A, DOUT_B, READY, WERR
    );

    modport slave (
        input  DIN, W, WADD, CLR, RADD_A, RADD_B,
        output DOUT_A, DOUT_B, READY, WERR
    );
endinterface

// File: rtl/diram_sweep.sv
// Dual-read, single-write register RAM with an init sweep after reset and on CLR.
// Define DIRAM_SWEEP_BYPASS_EN for write-first read ports; default is read-first.
module diram_sweep #(
    parameter int               WIDTH    = 6,
    parameter int               DEPTH    = 8,
    parameter int               AW       = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL = 6'b011111
) (
    input  logic         clk,
    input  logic         rst_n,
    diram_sweep_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             werr, werr_nxt;
    logic [WIDTH-1:0] dout_a, dout_b, dout_a_nxt, dout_b_nxt;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic             wadd_ok, write_ok;

    assign wadd_ok  = ({1'b0, bus.WADD} < DEPTH_W);
    assign write_ok = (state == RUN) && bus.W && !bus.CLR && wadd_ok;

    // Out-of-range read addresses look like freshly initialised words.
    always_comb begin
        rd_a = INIT_VAL;
        rd_b = INIT_VAL;
        if ({1'b0, bus.RADD_A} < DEPTH_W) begin
            rd_a = mem[bus.RADD_A];
        end
        if ({1'b0, bus.RADD_B} < DEPTH_W) begin
            rd_b = mem[bus.RADD_B];
        end
`ifdef DIRAM_SWEEP_BYPASS_EN
        if (write_ok && bus.RADD_A == bus.WADD) begin
            rd_a = bus.DIN;
        end
        if (write_ok && bus.RADD_B == bus.WADD) begin
            rd_b = bus.DIN;
        end
`endif
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mem_we     = 1'b0;
        mem_addr   = cnt;
        mem_data   = INIT_VAL;
        werr_nxt   = 1'b0;
        dout_a_nxt = INIT_VAL;
        dout_b_nxt = INIT_VAL;
        case (state)
            INIT: begin
                mem_we   = 1'b1;
                werr_nxt = bus.W;
                if (cnt == LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            RUN: begin
                // A write colliding with CLR is dropped and flagged like a bad address.
                werr_nxt   = bus.W && (bus.CLR || !wadd_ok);
                mem_we     = write_ok;
                mem_addr   = bus.WADD;
                mem_data   = bus.DIN;
                dout_a_nxt = rd_a;
                dout_b_nxt = rd_b;
                if (bus.CLR) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INIT;
            cnt    <= '0;
            werr   <= 1'b0;
            dout_a <= INIT_VAL;
            dout_b <= INIT_VAL;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            werr   <= werr_nxt;
            dout_a <= dout_a_nxt;
            dout_b <= dout_b_nxt;
        end
    end

    // Storage is deliberately unreset; the sweep rewrites every word instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    assign bus.READY  = (state == RUN);
    assign bus.WERR   = werr;
    assign bus.DOUT_A = dout_a;
    assign bus.DOUT_B = dout_b;
endmodule

// File: tb/tb_diram_sweep.sv
// Directed bench for diram_sweep: a default 8x6 instance driven from a vector table,
// plus a 6x8 instance exercising non-power-of-two depth and out-of-range addresses.
module tb_diram_sweep;
    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;
    int   tests_run = 0;
    int   tests_failed = 0;

`ifdef DIRAM_SWEEP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    diram_sweep_if #(.WIDTH(6), .AW(3)) bus0 ();
    diram_sweep_if #(.WIDTH(8), .AW(3)) bus1 ();

    diram_sweep #(.WIDTH(6), .DEPTH(8), .INIT_VAL(6'b011111)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(bus0)
    );
    diram_sweep #(.WIDTH(8), .DEPTH(6), .INIT_VAL(8'hFF)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1)
    );

    typedef struct {
        logic       w;
        logic [2:0] wadd;
        logic [5:0] din;
        logic       clr;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [5:0] ea;
        logic [5:0] eb;
        logic       erdy;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic w, input logic [2:0] wadd, input logic [5:0] din,
                           input logic clr, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [5:0] ea, input logic [5:0] eb,
                           input logic erdy, input logic eerr);
        vec_t v;
        v.w = w; v.wadd = wadd; v.din = din; v.clr = clr; v.ra = ra; v.rb = rb;
        v.ea = ea; v.eb = eb; v.erdy = erdy; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [2:0] wadd, input logic [5:0] din,
                                  input logic clr, input logic [2:0] ra, input logic [2:0] rb);
        bus0.W = w; bus0.WADD = wadd; bus0.DIN = din; bus0.CLR = clr;
        bus0.RADD_A = ra; bus0.RADD_B = rb;
    endtask

    task automatic apply_stimulus1(input logic w, input logic [2:0] wadd, input logic [7:0] din,
                                   input logic [2:0] ra, input logic [2:0] rb);
        bus1.W = w; bus1.WADD = wadd; bus1.DIN = din; bus1.CLR = 1'b0;
        bus1.RADD_A = ra; bus1.RADD_B = rb;
    endtask

    task automatic check0(input string name, input int idx, input logic [5:0] ea,
                          input logic [5:0] eb, input logic erdy, input logic eerr);
        check_output({name, ".dout_a"}, idx, {2'b00, bus0.DOUT_A}, {2'b00, ea});
        check_output({name, ".dout_b"}, idx, {2'b00, bus0.DOUT_B}, {2'b00, eb});
        check_output({name, ".ready"},  idx, {7'd0, bus0.READY}, {7'd0, erdy});
        check_output({name, ".werr"},   idx, {7'd0, bus0.WERR},  {7'd0, eerr});
    endtask

    task automatic check1(input string name, input int idx, input logic [7:0] ea,
                          input logic [7:0] eb, input logic erdy, input logic eerr);
        check_output({name, ".dout_a"}, idx, bus1.DOUT_A, ea);
        check_output({name, ".dout_b"}, idx, bus1.DOUT_B, eb);
        check_output({name, ".ready"},  idx, {7'd0, bus1.READY}, {7'd0, erdy});
        check_output({name, ".werr"},   idx, {7'd0, bus1.WERR},  {7'd0, eerr});
    endtask

    initial begin
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        apply_stimulus(1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 3'd0);
        apply_stimulus1(1'b0, 3'd0, 8'd0, 3'd0, 3'd0);

        // Read-back of the fresh table, writes, bypass cases, CLR with W, sweep after CLR.
        for (int i = 0; i < 8; i++) begin
            add_vec(1'b0, 3'd0, 6'd0, 1'b0, 3'(i), 3'(7 - i), 6'h1F, 6'h1F, 1'b1, 1'b0);
        end
        add_vec(1'b1, 3'd3, 6'h2A, 1'b0, 3'd0, 3'd1, 6'h1F, 6'h1F, 1'b1, 1'b0);
        add_vec(1'b0, 3'd0, 6'h00, 1'b0, 3'd3, 3'd3, 6'h2A, 6'h2A, 1'b1, 1'b0);
        add_vec(1'b1, 3'd5, 6'h15, 1'b0, 3'd5, 3'd3, BYP ? 6'h15 : 6'h1F, 6'h2A, 1'b1, 1'b0);
        add_vec(1'b0, 3'd0, 6'h00, 1'b0, 3'd5, 3'd5, 6'h15, 6'h15, 1'b1, 1'b0);
        add_vec(1'b1, 3'd7, 6'h3C, 1'b0, 3'd7, 3'd7, BYP ? 6'h3C : 6'h1F,
                BYP ? 6'h3C : 6'h1F, 1'b1, 1'b0);
        add_vec(1'b0, 3'd0, 6'h00, 1'b0, 3'd7, 3'd2, 6'h3C, 6'h1F, 1'b1, 1'b0);
        add_vec(1'b1, 3'd2, 6'h11, 1'b1, 3'd2, 3'd3, 6'h1F, 6'h2A, 1'b0, 1'b1);
        add_vec(1'b0, 3'd0, 6'h00, 1'b0, 3'd3, 3'd5, 6'h1F, 6'h1F, 1'b0, 1'b0);
        add_vec(1'b1, 3'd4, 6'h0A, 1'b0, 3'd3, 3'd5, 6'h1F, 6'h1F, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            add_vec(1'b0, 3'd0, 6'h00, 1'b0, 3'd5, 3'd7, 6'h1F, 6'h1F, i == 5, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            add_vec(1'b0, 3'd0, 6'd0, 1'b0, 3'(i), 3'(7 - i), 6'h1F, 6'h1F, 1'b1, 1'b0);
        end

        @(negedge clk);
        check0("reset0", 0, 6'h1F, 6'h1F, 1'b0, 1'b0);
        rst0_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check0("sweep0", i, 6'h1F, 6'h1F, i == 7, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].w, vecs[i].wadd, vecs[i].din, vecs[i].clr,
                           vecs[i].ra, vecs[i].rb);
            tick();
            check0("vec", i, vecs[i].ea, vecs[i].eb, vecs[i].erdy, vecs[i].eerr);
        end

        // Reset pulse in the middle of a CLR-started sweep.
        apply_stimulus(1'b1, 3'd1, 6'h2A, 1'b0, 3'd0, 3'd0);
        tick();
        apply_stimulus(1'b0, 3'd0, 6'h00, 1'b1, 3'd1, 3'd1);
        tick();
        check0("clr_read", 0, 6'h2A, 6'h2A, 1'b0, 1'b0);
        apply_stimulus(1'b0, 3'd0, 6'h00, 1'b0, 3'd1, 3'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        rst0_n = 1'b0;
        tick();
        check0("midreset", 0, 6'h1F, 6'h1F, 1'b0, 1'b0);
        rst0_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check0("resweep", i, 6'h1F, 6'h1F, i == 7, 1'b0);
        end
        tick();
        check0("resweep_rd", 0, 6'h1F, 6'h1F, 1'b1, 1'b0);

        // Six-deep, eight-bit instance: sweep length and out-of-range handling.
        check1("reset1", 0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        rst1_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check1("sweep1", i, 8'hFF, 8'hFF, i == 5, 1'b0);
        end
        apply_stimulus1(1'b1, 3'd7, 8'h00, 3'd0, 3'd1);
        tick();
        check1("oob7", 0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        apply_stimulus1(1'b1, 3'd6, 8'h00, 3'd0, 3'd1);
        tick();
        check1("oob6", 0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus1(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
            tick();
            check1("rd1", i, 8'hFF, 8'hFF, 1'b1, 1'b0);
        end
        apply_stimulus1(1'b1, 3'd0, 8'h5A, 3'd1, 3'd6);
        tick();
        check1("wr1", 0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        apply_stimulus1(1'b0, 3'd0, 8'h00, 3'd0, 3'd6);
        tick();
        check1("rd1_after", 0, 8'h5A, 8'hFF, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
